// File: rtl/fp_align_unit.sv
// Operand alignment for the FP add/sub datapath: right-shifts the smaller-exponent
// mantissa SHIFT_STEP bits per cycle with G/R/S collection. Optional macro: ALIGN_FAST_SAT_EN.
module fp_align_unit #(
  parameter int EXP_W      = 11,
  parameter int MAN_W      = 52,
  parameter int SHIFT_STEP = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAN_W-1:0]   a_man,
  input  logic [MAN_W-1:0]   b_man,
  input  logic [EXP_W-1:0]   a_exp,
  input  logic [EXP_W-1:0]   b_exp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MAN_W+3:0]   out_a_man,
  output logic [MAN_W+3:0]   out_b_man,
  output logic [EXP_W-1:0]   out_exp,
  output logic               out_b_shifted,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int MW    = MAN_W + 4;
  localparam int CNT_W = $clog2(MAN_W + 5);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(MW);
  localparam logic [CNT_W-1:0] STEP = CNT_W'(SHIFT_STEP);

  // Handshakes: a transfer happens on a rising edge where valid && ready && en.
  // valid holds its payload stable until the transfer; ready never depends on valid.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ALIGN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    a_man_q, a_man_d, b_man_q, b_man_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             bsh_q, bsh_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  logic             hid_a, hid_b, a_gt_b;
  logic [EXP_W-1:0] eff_a, eff_b, diff;
  logic [CNT_W-1:0] diff_sat, k;
  logic [MW-1:0]    ld_a, ld_b, sh_src, sh_res, sh_mask;

  always_comb begin
    hid_a    = (a_exp != '0);
    hid_b    = (b_exp != '0);
    eff_a    = hid_a ? a_exp : EXP_W'(1);
    eff_b    = hid_b ? b_exp : EXP_W'(1);
    a_gt_b   = (eff_a > eff_b);
    diff     = a_gt_b ? (eff_a - eff_b) : (eff_b - eff_a);
    diff_sat = (32'(diff) >= 32'(MW)) ? SAT : CNT_W'(diff);
    ld_a     = {hid_a, a_man, 3'b000};
    ld_b     = {hid_b, b_man, 3'b000};

    // Bits falling off the bottom in this step fold into the sticky bit.
    k        = (rem_q < STEP) ? rem_q : STEP;
    sh_src   = bsh_q ? b_man_q : a_man_q;
    sh_mask  = ~({MW{1'b1}} << k);
    sh_res   = sh_src >> k;
    sh_res[0] = sh_res[0] | (|(sh_src & sh_mask));
  end

  always_comb begin
    state_d = state_q;
    a_man_d = a_man_q;
    b_man_d = b_man_q;
    exp_d   = exp_q;
    bsh_d   = bsh_q;
    rem_d   = rem_q;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_man_d = ld_a;
            b_man_d = ld_b;
            exp_d   = a_gt_b ? eff_a : eff_b;
            bsh_d   = a_gt_b;
            rem_d   = diff_sat;
            state_d = (diff_sat == '0) ? S_DONE : S_ALIGN;
`ifdef ALIGN_FAST_SAT_EN
            if (diff_sat == SAT) begin
              rem_d   = '0;
              state_d = S_DONE;
              if (a_gt_b) b_man_d = {{(MW-1){1'b0}}, |ld_b};
              else        a_man_d = {{(MW-1){1'b0}}, |ld_a};
            end
`endif
          end
        end
        S_ALIGN: begin
          if (bsh_q) b_man_d = sh_res;
          else       a_man_d = sh_res;
          rem_d = rem_q - k;
          if (rem_q == k) state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_man_q <= '0;
      b_man_q <= '0;
      exp_q   <= '0;
      bsh_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      a_man_q <= a_man_d;
      b_man_q <= b_man_d;
      exp_q   <= exp_d;
      bsh_q   <= bsh_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign out_a_man     = a_man_q;
  assign out_b_man     = b_man_q;
  assign out_exp       = exp_q;
  assign out_b_shifted = bsh_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fp_align_unit.sv
// Scoreboard bench for fp_align_unit: directed cases, backpressure/enable gaps, random operands.
module tb_fp_align_unit;

  localparam int EXP_W = 11;
  localparam int MAN_W = 52;
  localparam int STEP  = 8;
  localparam int MW    = MAN_W + 4;
  localparam int LB    = 9 + EXP_W;
  localparam int AB    = LB + MW;
  localparam int EW    = AB + MW;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [MAN_W-1:0]   a_man = '0, b_man = '0;
  logic [EXP_W-1:0]   a_exp = '0, b_exp = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [MW-1:0]      out_a_man, out_b_man;
  logic [EXP_W-1:0]   out_exp;
  logic               out_b_shifted, busy;
  logic [1:0]         dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  fp_align_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .a_man(a_man), .b_man(b_man), .a_exp(a_exp), .b_exp(b_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_a_man(out_a_man),
    .out_b_man(out_b_man), .out_exp(out_exp), .out_b_shifted(out_b_shifted),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [MW-1:0] align_ref(input logic [MW-1:0] m, input int d);
    logic [MW-1:0] r;
    logic sticky;
    sticky = 1'b0;
    for (int i = 0; i < MW; i++) if (i < d) sticky = sticky | m[i];
    r = (d >= MW) ? '0 : (m >> d);
    r[0] = r[0] | sticky;
    return r;
  endfunction

  function automatic int lat_ref(input int d);
    int dd;
    dd = (d > MW) ? MW : d;
`ifdef ALIGN_FAST_SAT_EN
    if (dd == MW) return 1;
`endif
    return 1 + (dd + STEP - 1) / STEP;
  endfunction

  task automatic run_op(input logic [EXP_W-1:0] ae, input logic [EXP_W-1:0] be,
                        input logic [MAN_W-1:0] am, input logic [MAN_W-1:0] bm,
                        input int hold, input int gap);
    logic [EW-1:0] e;
    logic [MW-1:0] ma, mb, ra, rb;
    int ea, eb, d, lat;
    ea = (ae == 0) ? 1 : int'(ae);
    eb = (be == 0) ? 1 : int'(be);
    ma = {ae != 0, am, 3'b000};
    mb = {be != 0, bm, 3'b000};
    d  = (ea > eb) ? ea - eb : eb - ea;
    ra = (ea < eb) ? align_ref(ma, d) : ma;
    rb = (ea > eb) ? align_ref(mb, d) : mb;
    e  = {ra, rb, EXP_W'((ea > eb) ? ea : eb), (ea > eb), 8'(lat_ref(d))};
    exp_q.push_back(e);

    @(negedge clk);
    a_exp = ae; b_exp = be; a_man = am; b_man = bm; in_valid = 1'b1;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    if (gap > 0 && !out_valid) begin
      en = 1'b0;
      repeat (gap) begin @(posedge clk); #1; lat++; end
      check("en_freeze_state", 64'(dbg_state), 64'd1);
      en = 1'b1;
    end
    while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    e = exp_q.pop_front();
    check("out_valid_seen", 64'(out_valid), 64'd1);
    check("latency", 64'(lat), 64'(e[7:0]) + 64'(gap));
    check("out_a_man", 64'(out_a_man), 64'(e[AB +: MW]));
    check("out_b_man", 64'(out_b_man), 64'(e[LB +: MW]));
    check("out_exp", 64'(out_exp), 64'(e[9 +: EXP_W]));
    check("out_b_shifted", 64'(out_b_shifted), 64'(e[8]));
    if (hold > 0) begin
      in_valid = 1'b1; a_exp = ~ae; b_man = ~bm;
      repeat (hold) begin
        @(posedge clk); #1;
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_a_man", 64'(out_a_man), 64'(e[AB +: MW]));
        check("hold_b_man", 64'(out_b_man), 64'(e[LB +: MW]));
        check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0; en = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check("en_low_done_valid", 64'(out_valid), 64'd1);
      en = 1'b1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int x, y, seen;
    logic [63:0] r1, r2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_a_man", 64'(out_a_man), 64'd0);
    check("rst_exp", 64'(out_exp), 64'd0);
    check("rst_b_shifted", 64'(out_b_shifted), 64'd0);
    @(negedge clk); rst = 1'b1;

    run_op(11'd1023, 11'd1023, 52'd0, 52'd1, 0, 0);
    run_op(11'd1025, 11'd1023, 52'd0, 52'd0, 0, 0);
    run_op(11'd1000, 11'd1020, 52'd1, 52'd0, 0, 0);
    run_op(11'd2000, 11'd1, 52'd0, 52'd0, 0, 0);
    run_op(11'd1, 11'd2000, 52'hF_FFFF_FFFF_FFFF, 52'd5, 0, 0);
    run_op(11'd1030, 11'd1027, 52'h8_0000_0000_0007, 52'h1234, 5, 0);
    run_op(11'd1100, 11'd1140, 52'hA_5A5A_5A5A_5A5A, 52'h3, 0, 3);
    run_op(11'd0, 11'd0, 52'h0_0000_0000_00FF, 52'h8_0000_0000_0000, 0, 0);
    run_op(11'd0, 11'd1, 52'h7, 52'h9, 0, 0);
    run_op(11'd2047, 11'd2040, 52'h1, 52'h5_5555_5555_5555, 2, 0);
    run_op(11'd60, 11'd3, 52'h0, 52'h1, 0, 0);

    for (int i = 0; i < 12; i++) begin
      x = $urandom_range(0, 2047);
      y = x + $urandom_range(0, 80) - 40;
      if (y < 0) y = 0;
      if (y > 2047) y = 2047;
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      run_op(EXP_W'(x), EXP_W'(y), r1[MAN_W-1:0], r2[MAN_W-1:0],
             $urandom_range(0, 2), (i % 3 == 0) ? $urandom_range(1, 3) : 0);
    end

    // Abort mid-ALIGN: reset must kill the operation with no later output.
    @(negedge clk);
    a_exp = 11'd1040; b_exp = 11'd1000; a_man = '0; b_man = 52'hF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("abort_no_output", 64'(seen), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
